vend_controller: RTL and testbench

VEND_CONTROLLER -- requirements
Module: vend_controller

---
 rtl/vend_pkg.sv | 13 +
 rtl/vend_timeout_ctr.sv | 28 ++
 rtl/vend_controller.sv | 135 +++++++++++++
 tb/tb_vend_controller.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared constants for the vending controller.
// State encoding and coin unit values.
package vend_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CREDIT = 2'd1;
  localparam logic [1:0] ST_VEND   = 2'd2;
  localparam logic [1:0] ST_CHANGE = 2'd3;

  localparam int unsigned COIN5_UNITS  = 1;
  localparam int unsigned COIN10_UNITS = 2;

endpackage

// File: rtl/vend_timeout_ctr.sv
// Idle-cycle counter for the CREDIT auto-refund.
// Only built when VEND_TIMEOUT_EN is defined.
module vend_timeout_ctr #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

  logic [CW-1:0] cnt;

  assign expired = (cnt == LIMIT);

  // count idle cycles, saturating at the limit
  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en && !expired)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/vend_controller.sv
// Coin-operated vending controller: credit, vend, change.
// Optional CREDIT auto-refund when VEND_TIMEOUT_EN is defined.
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE_A     = 3,
  parameter int PRICE_B     = 4,
  parameter int CREDIT_W    = 5,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_5,
  input  logic                coin_10,
  input  logic                sel_valid,
  input  logic                sel_id,
  input  logic                cancel,
  output logic                dispense_valid,
  output logic                dispense_id,
  input  logic                dispense_ready,
  output logic                change_valid,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                sel_reject
);

  localparam logic [CREDIT_W:0] MAX_C = {1'b0, {CREDIT_W{1'b1}}};
  localparam logic [CREDIT_W-1:0] PA = CREDIT_W'(PRICE_A);
  localparam logic [CREDIT_W-1:0] PB = CREDIT_W'(PRICE_B);

  logic [1:0]          state, nxt_state;
  logic [CREDIT_W-1:0] cr_q, nxt_cr, base, price;
  logic                id_q, nxt_id;
  logic [CREDIT_W:0]   coin_add, sum;
  logic                coin_any, coin_ok, tmo, activity;

  assign coin_any = coin_5 | coin_10;
  assign activity = coin_any | sel_valid | cancel;
  assign price    = sel_id ? PB : PA;
  assign sum      = {1'b0, cr_q} + coin_add;
  assign coin_ok  = coin_any && sum <= MAX_C &&
                    (state == ST_IDLE || state == ST_CREDIT);

`ifdef VEND_TIMEOUT_EN
  vend_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != ST_CREDIT || activity),
    .en      (state == ST_CREDIT),
    .expired (tmo)
  );
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
  assign tmo = 1'b0;
`endif

  // coin value of this cycle's inserts
  always_comb begin
    coin_add = '0;
    if (coin_5)  coin_add = coin_add + (CREDIT_W+1)'(COIN5_UNITS);
    if (coin_10) coin_add = coin_add + (CREDIT_W+1)'(COIN10_UNITS);
  end

  // next-state, credit and reject decode
  always_comb begin
    nxt_state   = state;
    nxt_cr      = cr_q;
    nxt_id      = id_q;
    base        = cr_q;
    sel_reject  = 1'b0;
    coin_reject = coin_any && !coin_ok;
    unique case (state)
      ST_IDLE: begin
        sel_reject = sel_valid;
        if (coin_ok) begin
          nxt_cr    = sum[CREDIT_W-1:0];
          nxt_state = ST_CREDIT;
        end
      end
      ST_CREDIT: begin
        if (cancel) begin
          sel_reject = sel_valid;
          nxt_state  = ST_CHANGE;
        end else if (sel_valid) begin
          if (cr_q >= price) begin
            base      = cr_q - price;
            nxt_id    = sel_id;
            nxt_state = ST_VEND;
          end else begin
            sel_reject = 1'b1;
          end
        end else if (tmo) begin
          nxt_state = ST_CHANGE;
        end
        nxt_cr = coin_ok ? base + coin_add[CREDIT_W-1:0] : base;
      end
      ST_VEND: begin
        sel_reject = sel_valid;
        if (dispense_ready)
          nxt_state = (cr_q != '0) ? ST_CHANGE : ST_IDLE;
      end
      default: begin
        sel_reject = sel_valid;
        if (cr_q == '0) begin
          nxt_state = ST_IDLE;
        end else if (change_ready) begin
          nxt_cr = cr_q - 1'b1;
          if (cr_q == CREDIT_W'(1))
            nxt_state = ST_IDLE;
        end
      end
    endcase
  end

  // state, credit and product registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cr_q  <= '0;
      id_q  <= 1'b0;
    end else begin
      state <= nxt_state;
      cr_q  <= nxt_cr;
      id_q  <= nxt_id;
    end
  end

  assign credit         = cr_q;
  assign dispense_id    = id_q;
  assign dispense_valid = (state == ST_VEND);
  assign change_valid   = (state == ST_CHANGE) && (cr_q != '0);

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller.
// Timeout scenario follows VEND_TIMEOUT_EN.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       rst, coin_5, coin_10, sel_valid, sel_id, cancel;
  logic       dispense_valid, dispense_id, dispense_ready;
  logic       change_valid, change_ready;
  logic [4:0] credit;
  logic       coin_reject, sel_reject;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vend_controller dut (
    .clk            (clk),
    .rst            (rst),
    .coin_5         (coin_5),
    .coin_10        (coin_10),
    .sel_valid      (sel_valid),
    .sel_id         (sel_id),
    .cancel         (cancel),
    .dispense_valid (dispense_valid),
    .dispense_id    (dispense_id),
    .dispense_ready (dispense_ready),
    .change_valid   (change_valid),
    .change_ready   (change_ready),
    .credit         (credit),
    .coin_reject    (coin_reject),
    .sel_reject     (sel_reject)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    coin_5 = 0; coin_10 = 0; sel_valid = 0; sel_id = 0;
    cancel = 0; dispense_ready = 0; change_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr_in();
    #1;
  endtask

  task automatic coin(input logic c5, input logic c10);
    coin_5 = c5; coin_10 = c10;
    tick();
  endtask

  task automatic drain(output int units);
    units = 0;
    for (int i = 0; i < 40; i++) begin
      if (!change_valid) break;
      units++;
      change_ready = 1;
      tick();
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_cr"}, credit, 0);
    chk({tag, "_dv"}, dispense_valid, 0);
    chk({tag, "_di"}, dispense_id, 0);
    chk({tag, "_cv"}, change_valid, 0);
    chk({tag, "_crj"}, coin_reject, 0);
    chk({tag, "_srj"}, sel_reject, 0);
  endtask

  int  u;
  logic seen;

  initial begin
    clr_in();
    rst = 1;
    tick();
    tick();
    rst = 0;
    all_zero("rst");

    // A at exact price, no change
    coin(0, 1);
    chk("s1_c2", credit, 2);
    coin(1, 0);
    chk("s1_c3", credit, 3);
    sel_valid = 1; sel_id = 0;
    #1 chk("s1_srj", sel_reject, 0);
    tick();
    chk("s1_cr0", credit, 0);
    chk("s1_dv", dispense_valid, 1);
    chk("s1_id", dispense_id, 0);
    dispense_ready = 1;
    tick();
    chk("s1_dv0", dispense_valid, 0);
    chk("s1_cv0", change_valid, 0);

    // B with two units change
    coin(0, 1); coin(0, 1); coin(0, 1);
    chk("s2_c6", credit, 6);
    sel_valid = 1; sel_id = 1;
    tick();
    chk("s2_cr", credit, 2);
    chk("s2_id", dispense_id, 1);
    coin_5 = 1; sel_valid = 1;
    #1 chk("s2_vcrj", coin_reject, 1);
    chk("s2_vsrj", sel_reject, 1);
    tick();
    chk("s2_hold", dispense_valid, 1);
    chk("s2_idh", dispense_id, 1);
    chk("s2_crh", credit, 2);
    dispense_ready = 1;
    tick();
    chk("s2_cv", change_valid, 1);
    drain(u);
    chk("s2_units", u, 2);
    chk("s2_end", credit, 0);

    // insufficient credit then cancel
    coin(1, 0);
    sel_valid = 1; sel_id = 1;
    #1 chk("s3_srj", sel_reject, 1);
    tick();
    chk("s3_cr", credit, 1);
    chk("s3_dv", dispense_valid, 0);
    cancel = 1;
    tick();
    chk("s3_cv", change_valid, 1);
    tick();
    chk("s3_held", change_valid, 1);
    drain(u);
    chk("s3_units", u, 1);

    // overflow boundary
    for (int i = 0; i < 10; i++) coin(1, 1);
    chk("s4_c30", credit, 30);
    coin_10 = 1;
    #1 chk("s4_rj", coin_reject, 1);
    tick();
    chk("s4_c30b", credit, 30);
    coin_5 = 1;
    #1 chk("s4_ok", coin_reject, 0);
    tick();
    chk("s4_c31", credit, 31);
    rst = 1;
    tick();
    rst = 0;
    all_zero("s4_rst");

    // cancel wins over select
    coin(0, 1); coin(0, 1);
    sel_valid = 1; sel_id = 0; cancel = 1;
    tick();
    chk("s5_dv", dispense_valid, 0);
    chk("s5_cr", credit, 4);
    drain(u);
    chk("s5_units", u, 4);
    chk("s5_dv2", dispense_valid, 0);

    // idle credit: auto-refund or hold
    coin(1, 0);
`ifdef VEND_TIMEOUT_EN
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (change_valid) begin
        seen = 1;
        break;
      end
      tick();
    end
    chk("s6_tmo", seen, 1);
    drain(u);
    chk("s6_units", u, 1);
`else
    for (int i = 0; i < 300; i++) tick();
    chk("s6_hold", credit, 1);
    chk("s6_cv", change_valid, 0);
    cancel = 1;
    tick();
    drain(u);
    chk("s6_units", u, 1);
`endif

    // reset during change discards credit
    coin(0, 1);
    cancel = 1;
    tick();
    chk("s7_cv", change_valid, 1);
    change_ready = 1; rst = 1;
    tick();
    rst = 0;
    all_zero("s7_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
